// File: rtl/id_redirect_if.sv
// Fetch <-> decode link: fetch presents instr/pc, decode returns redirect targets.
interface id_redirect_if;
  // No handshake: fetch presents one instr/pc every cycle, and each address is
  // meaningful only in a cycle where its ctrl bit is 1; jump_ctrl outranks branch_ctrl.
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] branch_address;
  logic        branch_ctrl;
  logic [31:0] jump_address;
  logic        jump_ctrl;

  modport master (
    output instr, pc,
    input  branch_address, branch_ctrl, jump_address, jump_ctrl
  );

  modport slave (
    input  instr, pc,
    output branch_address, branch_ctrl, jump_address, jump_ctrl
  );
endinterface

// File: rtl/id_redirect.sv
// IF/ID register plus branch/jump resolution. The instruction that follows a
// redirect is squashed unless delay-slot semantics are selected.
module id_redirect #(
  parameter int DELAY_SLOT = 0,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  id_redirect_if.slave       fetch,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic               id_valid,
  output logic               link_we,
  output logic [31:0]        link_data,
  output logic [COUNT_W-1:0] redirect_count,
  output logic               squash_state
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state;
  state_t      state_next;
  logic        load_bubble;
  logic        redirect;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_jr;
  logic        branch_taken;
  logic        jump_taken;
  logic [31:0] pc_plus4;

  // Decode of the instruction held in ID
  always_comb begin
    op           = id_instr[31:26];
    funct        = id_instr[5:0];
    is_jr        = (op == OP_SPECIAL) && (funct == FN_JR);
    branch_taken = id_valid && (((op == OP_BEQ) && (rs_data == rt_data)) ||
                                ((op == OP_BNE) && (rs_data != rt_data)));
    jump_taken   = id_valid && ((op == OP_J) || (op == OP_JAL) || is_jr);
    redirect     = branch_taken || jump_taken;
    pc_plus4     = id_pc + 32'd4;
  end

  assign fetch.branch_ctrl    = branch_taken;
  assign fetch.jump_ctrl      = jump_taken;
  assign fetch.branch_address = pc_plus4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign fetch.jump_address   = is_jr ? rs_data : {pc_plus4[31:28], id_instr[25:0], 2'b00};
  assign link_we              = id_valid && (op == OP_JAL);
  assign link_data            = id_pc + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);
  assign squash_state         = (state == SQUASH);

  // A bubble in ID never redirects, so SQUASH simply loads normally and returns.
  always_comb begin
    state_next  = RUN;
    load_bubble = 1'b0;
    case (state)
      RUN: begin
        if (redirect && (DELAY_SLOT == 0)) begin
          state_next  = SQUASH;
          load_bubble = 1'b1;
        end
      end
      SQUASH: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      id_instr       <= 32'd0;
      id_pc          <= 32'd0;
      id_valid       <= 1'b0;
      redirect_count <= '0;
    end else begin
      state    <= state_next;
      id_instr <= load_bubble ? 32'd0 : fetch.instr;
      id_pc    <= fetch.pc;
      id_valid <= !load_bubble;
      if (redirect && (redirect_count != COUNT_MAX))
        redirect_count <= redirect_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_redirect.sv
// Bench for id_redirect: one squashing instance (2-bit counter) and one
// delay-slot instance fed the same fetch stream, checked against a reference model.
module tb_id_redirect;

  logic        clk;
  logic        rst;
  logic [31:0] rs_v;
  logic [31:0] rt_v;

  id_redirect_if if0();
  id_redirect_if if1();

  logic [31:0] id_instr0, id_pc0, link_data0;
  logic        id_valid0, link_we0, sq0;
  logic [1:0]  cnt0;
  logic [31:0] id_instr1, id_pc1, link_data1;
  logic        id_valid1, link_we1, sq1;
  logic [15:0] cnt1;

  id_redirect #(.DELAY_SLOT(0), .COUNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .fetch(if0), .rs_data(rs_v), .rt_data(rt_v),
    .id_instr(id_instr0), .id_pc(id_pc0), .id_valid(id_valid0),
    .link_we(link_we0), .link_data(link_data0), .redirect_count(cnt0),
    .squash_state(sq0)
  );

  id_redirect #(.DELAY_SLOT(1), .COUNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .fetch(if1), .rs_data(rs_v), .rt_data(rt_v),
    .id_instr(id_instr1), .id_pc(id_pc1), .id_valid(id_valid1),
    .link_we(link_we1), .link_data(link_data1), .redirect_count(cnt1),
    .squash_state(sq1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid, sq, br, jc, lw;
    logic [31:0] instr, pc, ba, ja, ld, cnt;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: what each instance holds in ID
  logic        m_valid[2];
  logic        m_sq[2];
  logic [31:0] m_instr[2];
  logic [31:0] m_pc[2];
  int          m_cnt[2];
  bit          ds[2]   = '{1'b0, 1'b1};
  int          cmax[2] = '{3, 65535};

  function automatic exp_t predict(int d);
    exp_t        e;
    logic [5:0]  op;
    int signed   off;
    op      = m_instr[d][31:26];
    e.valid = m_valid[d];
    e.sq    = m_sq[d];
    e.instr = m_instr[d];
    e.pc    = m_pc[d];
    e.br    = m_valid[d] && ((op == 6'h04 && rs_v == rt_v) || (op == 6'h05 && rs_v != rt_v));
    e.jc    = m_valid[d] && (op == 6'h02 || op == 6'h03 || (op == 6'h00 && m_instr[d][5:0] == 6'h08));
    e.lw    = m_valid[d] && op == 6'h03;
    off     = 32'($signed(m_instr[d][15:0]));
    e.ba    = m_pc[d] + 32'd4 + 32'(off * 4);
    if (op == 6'h00) e.ja = rs_v;
    else e.ja = ((m_pc[d] + 32'd4) & 32'hF000_0000) + 32'(m_instr[d][25:0]) * 32'd4;
    e.ld    = m_pc[d] + (ds[d] ? 32'd8 : 32'd4);
    e.cnt   = 32'(m_cnt[d]);
    return e;
  endfunction

  // driver: present one fetch slot, advance the model across the coming edge
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] p);
    exp_t cur;
    bit   red, bubble;
    rst = r;
    if0.instr = ins; if0.pc = p;
    if1.instr = ins; if1.pc = p;
    for (int d = 0; d < 2; d++) begin
      if (!r) begin
        m_valid[d] = 1'b0; m_sq[d] = 1'b0; m_instr[d] = '0; m_pc[d] = '0; m_cnt[d] = 0;
      end else begin
        cur    = predict(d);
        red    = cur.br || cur.jc;
        if (red && m_cnt[d] < cmax[d]) m_cnt[d]++;
        bubble     = red && !ds[d];
        m_valid[d] = !bubble;
        m_sq[d]    = bubble;
        m_instr[d] = bubble ? 32'd0 : ins;
        m_pc[d]    = p;
      end
      if (d == 0) exp_q0.push_back(predict(d));
      else        exp_q1.push_back(predict(d));
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [31:0] a, input logic [31:0] b);
    rs_v = a;
    rt_v = b;
  endtask

  // scoreboard
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%h req=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_dut(input int d, input exp_t e, input logic v, input logic [31:0] ins,
                           input logic [31:0] p, input logic br, input logic [31:0] ba,
                           input logic jc, input logic [31:0] ja, input logic lw,
                           input logic [31:0] ld, input logic [31:0] cnt, input logic sq);
    string t;
    t = $sformatf("d%0d.", d);
    cmp({t, "id_valid"}, 32'(v), 32'(e.valid));
    cmp({t, "id_instr"}, ins, e.instr);
    cmp({t, "id_pc"}, p, e.pc);
    cmp({t, "branch_ctrl"}, 32'(br), 32'(e.br));
    cmp({t, "jump_ctrl"}, 32'(jc), 32'(e.jc));
    cmp({t, "link_we"}, 32'(lw), 32'(e.lw));
    cmp({t, "link_data"}, ld, e.ld);
    cmp({t, "redirect_count"}, cnt, e.cnt);
    cmp({t, "squash_state"}, 32'(sq), 32'(e.sq));
    if (e.br) cmp({t, "branch_address"}, ba, e.ba);
    if (e.jc) cmp({t, "jump_address"}, ja, e.ja);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check_dut(0, e, id_valid0, id_instr0, id_pc0, if0.branch_ctrl, if0.branch_address,
                  if0.jump_ctrl, if0.jump_address, link_we0, link_data0, 32'(cnt0), sq0);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check_dut(1, e, id_valid1, id_instr1, id_pc1, if1.branch_ctrl, if1.branch_address,
                  if1.jump_ctrl, if1.jump_address, link_we1, link_data1, 32'(cnt1), sq1);
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] ins, p;
    set_regs(32'd0, 32'd0);
    step(1'b0, 32'h1000FFFF, 32'h0);
    step(1'b0, 32'h1000FFFF, 32'h0);
    step(1'b1, 32'h0, 32'h3C);
    // beq taken, imm 3
    set_regs(32'd5, 32'd5);
    step(1'b1, 32'h10220003, 32'h40);
    step(1'b1, 32'h0, 32'h44);
    step(1'b1, 32'h0, 32'h50);
    // bne not taken, then taken back to 0xFC
    step(1'b1, 32'h1422FFFE, 32'h100);
    step(1'b1, 32'h0, 32'h104);
    set_regs(32'd1, 32'd2);
    step(1'b1, 32'h1422FFFE, 32'h100);
    step(1'b1, 32'h0, 32'h104);
    step(1'b1, 32'h0, 32'hFC);
    // jal
    step(1'b1, 32'h0C000040, 32'h3000_0010);
    step(1'b1, 32'h0, 32'h3000_0014);
    step(1'b1, 32'h0, 32'h3000_0100);
    // jr
    set_regs(32'h200, 32'd0);
    step(1'b1, 32'h00200008, 32'h80);
    step(1'b1, 32'h0, 32'h84);
    step(1'b1, 32'h0, 32'h200);
    // reset while squashing, then branch-to-self to saturate the 2-bit counter
    set_regs(32'd7, 32'd7);
    step(1'b1, 32'h10220003, 32'h40);
    step(1'b1, 32'h0, 32'h44);
    step(1'b0, 32'h0, 32'h50);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h1022FFFF, 32'h400);
    // back-to-back branches
    step(1'b1, 32'h10220002, 32'h500);
    step(1'b1, 32'h10220004, 32'h504);
    step(1'b1, 32'h0, 32'h50C);
    // targets wrapping near the top of memory
    step(1'b1, 32'h10220001, 32'hFFFF_FFFC);
    step(1'b1, 32'h0C000010, 32'hFFFF_FFFC);
    step(1'b1, 32'h0, 32'h0);
    step(1'b1, 32'h0, 32'h4);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: ins = {6'h04, 10'($urandom()), 16'($urandom())};
        1: ins = {6'h05, 10'($urandom()), 16'($urandom())};
        2: ins = {6'h02, 26'($urandom())};
        3: ins = {6'h03, 26'($urandom())};
        4: ins = {6'h00, 5'($urandom()), 15'd0, 6'h08};
        5: ins = {6'h00, 20'($urandom()), 6'h20};
        default: ins = $urandom();
      endcase
      p = $urandom() & 32'hFFFF_FFFC;
      set_regs($urandom_range(0, 3), $urandom_range(0, 3));
      step(($urandom_range(0, 39) != 0), ins, p);
    end
    step(1'b1, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    cmp("q0_drain", 32'(exp_q0.size()), 32'd0);
    cmp("q1_drain", 32'(exp_q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_redirect.md
Name: id_redirect

Overview:
- Decode-side counterpart of the fetch phase.
- Registers each fetched {instr, pc} into an IF/ID pipeline register.
- Resolves branches and jumps for the instruction in ID, and drives branch_address/branch_ctrl and jump_address/jump_ctrl back to the fetch muxes.
- Squashes the wrong-path instruction, reports link writes for jal, and keeps a redirect counter.

Parameters:
- DELAY_SLOT, 0, 1 = MIPS delay-slot semantics (instruction after a redirect executes); 0 = that instruction is squashed.
- COUNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- instr  in  32  instruction from fetch.
- pc  in  32  address of instr.
- rs_data  in  32  register-file read of id_instr[25:21], combinational.
- rt_data  in  32  register-file read of id_instr[20:16], combinational.
- branch_address  out  32  taken-branch target.
- branch_ctrl  out  1  select branch_address as next PC.
- jump_address  out  32  jump target.
- jump_ctrl  out  1  select jump_address as next PC (fetch gives it priority over branch).
- id_instr  out  32  instruction held in ID.
- id_pc  out  32  PC held in ID.
- id_valid  out  1  ID holds a live instruction.
- link_we  out  1  jal in ID: write link_data to $31.
- link_data  out  32  return address.
- redirect_count  out  COUNT_W  number of redirects taken, saturating.

Behaviour:
- Reset (rst==0 at the edge):
  - id_instr=0, id_pc=0, id_valid=0, redirect_count=0, state=RUN.
  - All combinational outputs derive from id_valid=0, so branch_ctrl=jump_ctrl=link_we=0.
  - Reset mid-operation discards the ID contents and any pending squash on that edge.
- State machine, states RUN and SQUASH:
  - RUN: each edge loads id_instr<=instr, id_pc<=pc, id_valid<=1.
  - RUN, redirect asserted this cycle and DELAY_SLOT=0: next state SQUASH. The load still happens, but id_valid<=0 and id_instr<=0 (NOP bubble).
  - SQUASH: acts as RUN for the next load, then returns to RUN. Because a bubble has id_valid=0, it can never issue a redirect.
  - DELAY_SLOT=1: SQUASH is never entered.
- Decode, combinational from ID register, qualified by id_valid (op = id_instr[31:26]):
  - beq (6'h04): branch_ctrl = (rs_data==rt_data).
  - bne (6'h05): branch_ctrl = (rs_data!=rt_data).
  - j (6'h02): jump_ctrl=1.
  - jal (6'h03): jump_ctrl=1, link_we=1.
  - jr (op 0, funct 6'h08): jump_ctrl=1.
  - All other encodings: no redirect.
- Arithmetic (mod 2^32, no overflow flag):
  - branch_address = id_pc + 4 + (sign-extended id_instr[15:0] << 2).
  - j/jal jump_address = {(id_pc+4)[31:28], id_instr[25:0], 2'b00}.
  - jr jump_address = rs_data.
  - link_data = id_pc + 8 if DELAY_SLOT=1, else id_pc + 4.
- Idle output values: branch_address and jump_address are don't-care when their ctrl is 0. Drive them from the decode anyway; do not force them to 0.
- Latency and penalty: a redirect takes effect on the edge after the branch enters ID. Penalty is 1 cycle (DELAY_SLOT=0) or 0 lost cycles (DELAY_SLOT=1).
- redirect_count:
  - Increments on each edge where branch_ctrl|jump_ctrl is 1.
  - Holds at 2^COUNT_W-1.
- Boundary cases:
  - Branch to self: redirects every valid occurrence; with DELAY_SLOT=0 the pattern alternates valid/bubble.
  - Back-to-back branches, DELAY_SLOT=1: a branch in the delay slot redirects normally.
  - pc near 32'hFFFFFFFC: targets wrap mod 2^32.

Test Plan:
- Hold rst=0 for 2 cycles with instr=32'h1000FFFF: id_valid=0, branch_ctrl=0, jump_ctrl=0, redirect_count=0. Release rst: id_valid=1 one edge later.
- DELAY_SLOT=0, beq at pc=0x40, imm=0x0003, rs_data=rt_data=5: branch_ctrl=1, branch_address=0x50. Next ID is a bubble (id_valid=0). The following ID has id_pc=0x50. redirect_count=1.
- bne at pc=0x100, imm=0xFFFE, rs_data=rt_data: branch_ctrl=0, no squash. With rs_data!=rt_data: branch_address=0xFC.
- jal at pc=0x3000_0010, target field 0x0000040: jump_ctrl=1, jump_address=0x3000_0100, link_we=1. link_data=0x3000_0014 (DELAY_SLOT=0) or 0x3000_0018 (DELAY_SLOT=1).
- jr with rs_data=0x0000_0200, DELAY_SLOT=1: jump_ctrl=1, jump_address=0x200. The next instruction enters ID with id_valid=1 (no squash).
- Drive rst=0 while state=SQUASH: after that edge id_valid=0, redirect_count=0, state=RUN. COUNT_W=2 with 5 redirects: redirect_count saturates at 3.
